parallel_peak_detector: RTL and testbench

- Hardware sink for the 2-parallel FIR output stream; replaces bench-side peak scanning with synthesizable logic.
- On `start`, it skips a settling interval, then tracks the signed maximum across all lanes over a fixed window of valid cycles.
- It reports the peak, the lane and cycle index where the peak occurred, and a one-cycle `done` pulse.
- It sits directly after parallel_2_filter, feeding magnitude/frequency-response measurement logic.

---
 rtl/fir_meas_pkg.sv | 22 ++
 rtl/parallel_peak_detector_if.sv | 28 ++
 rtl/lane_max.sv | 27 ++
 rtl/parallel_peak_detector.sv | 147 ++++++++++++++
 tb/tb_parallel_peak_detector.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fir_meas_pkg.sv
// Shared constants and types for the FIR measurement sink blocks.
package fir_meas_pkg;

    localparam int DATA_W_DEF = 40;
    localparam int LANES_DEF  = 2;
    localparam int CNT_W_DEF  = 16;

    // Width of a lane index; a single lane still gets one bit.
    function automatic int lane_width(input int lanes);
        return (lanes > 32'sd1) ? $clog2(lanes) : 32'sd1;
    endfunction

    localparam int LANE_W_DEF = lane_width(LANES_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/parallel_peak_detector_if.sv
// Sample stream in, measurement result out, for the parallel peak detector.
interface parallel_peak_detector_if
    import fir_meas_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int LANE_W = lane_width(LANES)
);
    logic                           start;
    logic [LANES-1:0][DATA_W-1:0]   samp;
    logic                           samp_valid;
    logic                           busy;
    logic                           done;
    logic signed [DATA_W-1:0]       peak;
    logic [LANE_W-1:0]              peak_lane;
    logic [CNT_W-1:0]               peak_index;

    modport master (
        output start, samp, samp_valid,
        input  busy, done, peak, peak_lane, peak_index
    );

    modport slave (
        input  start, samp, samp_valid,
        output busy, done, peak, peak_lane, peak_index
    );
endinterface

// File: rtl/lane_max.sv
// Combinational reduction of one lane set to its signed maximum and lane.
module lane_max #(
    parameter int DATA_W = 40,
    parameter int LANES  = 2,
    parameter int LANE_W = 1
) (
    input  logic [LANES-1:0][DATA_W-1:0] samp,
    output logic signed [DATA_W-1:0]     max_val,
    output logic [LANE_W-1:0]            max_lane
);

    // Strictly-greater scan from lane 0 upward so ties keep the lower lane.
    always_comb begin
        max_val  = $signed(samp[0]);
        max_lane = {LANE_W{1'b0}};
        for (int i = 1; i < LANES; i++) begin
            if ($signed(samp[i]) > max_val) begin
                max_val  = $signed(samp[i]);
                max_lane = LANE_W'(i);
            end else begin
                max_val  = max_val;
                max_lane = max_lane;
            end
        end
    end

endmodule

// File: rtl/parallel_peak_detector.sv
// Settles, then scans a fixed window of valid lane sets for the signed peak
// and publishes peak value, lane and window index with a one-cycle done.
module parallel_peak_detector
    import fir_meas_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int LANES         = LANES_DEF,
    parameter int SETTLE_CYCLES = 340,
    parameter int WINDOW_CYCLES = 2000,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    parallel_peak_detector_if.slave  bus
);

    localparam int LANE_W = lane_width(LANES);
    localparam logic [CNT_W-1:0] SET_LAST =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam state_t START_STATE = (SETTLE_CYCLES == 0) ? MEASURE : SETTLE;

    state_t                   state_r, state_next_s;
    logic [CNT_W-1:0]         cnt_r, cnt_next_s;
    logic signed [DATA_W-1:0] max_r, max_next_s;
    logic [LANE_W-1:0]        lane_r, lane_next_s;
    logic [CNT_W-1:0]         idx_r, idx_next_s;
    logic                     publish_s;

    logic                     busy_r, done_r;
    logic signed [DATA_W-1:0] peak_r;
    logic [LANE_W-1:0]        peak_lane_r;
    logic [CNT_W-1:0]         peak_index_r;

    logic signed [DATA_W-1:0] lm_val_s;
    logic [LANE_W-1:0]        lm_lane_s;

    lane_max #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_max (
        .samp     (bus.samp),
        .max_val  (lm_val_s),
        .max_lane (lm_lane_s)
    );

    // Next-state, counter and running-max update; publish on the last window sample.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        max_next_s   = max_r;
        lane_next_s  = lane_r;
        idx_next_s   = idx_r;
        publish_s    = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next_s = START_STATE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETTLE: begin
                if (bus.samp_valid) begin
                    if (cnt_r == SET_LAST) begin
                        state_next_s = MEASURE;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_next_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            MEASURE: begin
                if (bus.samp_valid) begin
                    // The first window cycle seeds the max; later ones need strictly greater.
                    if ((cnt_r == {CNT_W{1'b0}}) || (lm_val_s > max_r)) begin
                        max_next_s  = lm_val_s;
                        lane_next_s = lm_lane_s;
                        idx_next_s  = cnt_r;
                    end else begin
                        max_next_s = max_r;
                    end
                    if (cnt_r == WIN_LAST) begin
                        state_next_s = DONE;
                        cnt_next_s   = {CNT_W{1'b0}};
                        publish_s    = 1'b1;
                    end else begin
                        cnt_next_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and running-max registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            max_r   <= {DATA_W{1'b0}};
            lane_r  <= {LANE_W{1'b0}};
            idx_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            max_r   <= max_next_s;
            lane_r  <= lane_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Registered outputs; the result only moves on the publishing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            peak_r       <= {DATA_W{1'b0}};
            peak_lane_r  <= {LANE_W{1'b0}};
            peak_index_r <= {CNT_W{1'b0}};
        end else begin
            busy_r <= (state_next_s == SETTLE) || (state_next_s == MEASURE);
            done_r <= publish_s;
            if (publish_s) begin
                peak_r       <= max_next_s;
                peak_lane_r  <= lane_next_s;
                peak_index_r <= idx_next_s;
            end
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.peak       = peak_r;
    assign bus.peak_lane  = peak_lane_r;
    assign bus.peak_index = peak_index_r;

endmodule

// File: tb/tb_parallel_peak_detector.sv
// Directed bench: a 4-settle/8-window detector and a 0-settle/1-window detector.
module tb_parallel_peak_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt_a = 0;
    int   done_seen;

    always #5 clk = ~clk;

    parallel_peak_detector_if #(.DATA_W(40), .LANES(2), .CNT_W(16)) bus_a ();
    parallel_peak_detector_if #(.DATA_W(40), .LANES(2), .CNT_W(16)) bus_b ();

    parallel_peak_detector #(
        .DATA_W(40), .LANES(2), .SETTLE_CYCLES(4), .WINDOW_CYCLES(8), .CNT_W(16)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    parallel_peak_detector #(
        .DATA_W(40), .LANES(2), .SETTLE_CYCLES(0), .WINDOW_CYCLES(1), .CNT_W(16)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Count done pulses on detector A, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_a.done) done_cnt_a <= done_cnt_a + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input longint l0, input longint l1);
        bus_a.samp_valid = v;
        bus_a.samp[0]    = 40'(l0);
        bus_a.samp[1]    = 40'(l1);
        tick();
    endtask

    task automatic start_a();
        bus_a.start = 1'b1;
        step(1'b0, 0, 0);
        bus_a.start = 1'b0;
    endtask

    task automatic check_result(input string tag, input longint pk, input int ln, input int ix);
        check({tag, "_done"}, 64'(bus_a.done), 64'd1);
        check({tag, "_peak"}, 64'(bus_a.peak), 64'(40'(pk)));
        check({tag, "_lane"}, 64'(bus_a.peak_lane), 64'(ln));
        check({tag, "_idx"},  64'(bus_a.peak_index), 64'(ix));
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.samp_valid = 1'b0; bus_a.samp = '0;
        bus_b.start = 1'b0; bus_b.samp_valid = 1'b0; bus_b.samp = '0;
        tick(); tick();
        check("rst_busy", 64'(bus_a.busy), 64'd0);
        check("rst_done", 64'(bus_a.done), 64'd0);
        check("rst_peak", 64'(bus_a.peak), 64'd0);
        check("rst_lane", 64'(bus_a.peak_lane), 64'd0);
        check("rst_idx",  64'(bus_a.peak_index), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1. Basic peak
        done_seen = done_cnt_a;
        start_a();
        check("s1_busy", 64'(bus_a.busy), 64'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 1000, 0);
        for (int i = 0; i < 7; i++) step(1'b1, i, 10 * i);
        check("s1_early_done", 64'(bus_a.done), 64'd0);
        step(1'b1, 7, 70);
        check_result("s1", 70, 1, 7);
        step(1'b0, 0, 0);
        check("s1_done_drop", 64'(bus_a.done), 64'd0);
        check("s1_busy_drop", 64'(bus_a.busy), 64'd0);
        check("s1_done_once", 64'(done_cnt_a - done_seen), 64'd1);

        // 2. Gapped valid; invalid cycles carry junk that must be ignored
        start_a();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1000, 0);
            step(1'b0, 5000, 5000);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b1, i, 10 * i);
            step(1'b0, 9000, 9000);
        end
        check("s2_early_done", 64'(bus_a.done), 64'd0);
        check("s2_busy", 64'(bus_a.busy), 64'd1);
        step(1'b1, 7, 70);
        check_result("s2", 70, 1, 7);
        step(1'b0, 0, 0);

        // 3a. Negatives with one less-negative value
        start_a();
        for (int i = 0; i < 4; i++) step(1'b1, 100, 100);
        for (int i = 0; i < 8; i++) step(1'b1, -5, (i == 3) ? -2 : -5);
        check_result("s3a", -2, 1, 3);
        step(1'b0, 0, 0);

        // 3b. All equal: lower lane, earliest index
        start_a();
        for (int i = 0; i < 4; i++) step(1'b1, 100, 100);
        for (int i = 0; i < 8; i++) step(1'b1, -7, -7);
        check_result("s3b", -7, 0, 0);
        step(1'b0, 0, 0);

        // 4. Zero settle, single-cycle window on detector B
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        check("s4_busy", 64'(bus_b.busy), 64'd1);
        check("s4_pre_done", 64'(bus_b.done), 64'd0);
        bus_b.samp_valid = 1'b1;
        bus_b.samp[0] = 40'h7F_FFFF_FFFF;
        bus_b.samp[1] = 40'h00_0000_0000;
        tick();
        bus_b.samp_valid = 1'b0;
        check("s4_done", 64'(bus_b.done), 64'd1);
        check("s4_peak", 64'(bus_b.peak), 64'h0000_007F_FFFF_FFFF);
        check("s4_lane", 64'(bus_b.peak_lane), 64'd0);
        check("s4_idx",  64'(bus_b.peak_index), 64'd0);
        tick();
        check("s4_done_drop", 64'(bus_b.done), 64'd0);

        // 5. Ignored mid-window start, then back-to-back from DONE
        start_a();
        for (int i = 0; i < 4; i++) step(1'b1, 1000, 0);
        for (int i = 0; i < 8; i++) begin
            bus_a.start = (i == 2);
            step(1'b1, 3 * i, 0);
        end
        bus_a.start = 1'b0;
        check_result("s5a", 21, 0, 7);
        bus_a.start = 1'b1;
        step(1'b0, 0, 0);
        bus_a.start = 1'b0;
        check("s5_restart_busy", 64'(bus_a.busy), 64'd1);
        check("s5_restart_done", 64'(bus_a.done), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1000, 0);
        for (int i = 0; i < 7; i++) step(1'b1, 0, 100 - i);
        check("s5_hold_peak", 64'(bus_a.peak), 64'd21);
        check("s5_hold_done", 64'(bus_a.done), 64'd0);
        step(1'b1, 0, 93);
        check_result("s5b", 100, 1, 0);
        step(1'b0, 0, 0);

        // 6. Reset mid-measure, then a clean run
        start_a();
        for (int i = 0; i < 4; i++) step(1'b1, 1000, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 500, 0);
        done_seen = done_cnt_a;
        rst_n = 1'b0;
        #1;
        check("s6_busy", 64'(bus_a.busy), 64'd0);
        check("s6_done", 64'(bus_a.done), 64'd0);
        check("s6_peak", 64'(bus_a.peak), 64'd0);
        check("s6_lane", 64'(bus_a.peak_lane), 64'd0);
        check("s6_idx",  64'(bus_a.peak_index), 64'd0);
        step(1'b1, 500, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 500, 0);
        check("s6_no_done", 64'(done_cnt_a - done_seen), 64'd0);
        check("s6_idle", 64'(bus_a.busy), 64'd0);
        start_a();
        for (int i = 0; i < 4; i++) step(1'b1, 1000, 0);
        for (int i = 0; i < 8; i++) step(1'b1, i - 20, -100);
        check_result("s6", -13, 0, 7);
        step(1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
